// File: rtl/instr_encoder_if.sv
// Field-bundle stream in, instruction-memory write port out, plus session status.
interface instr_encoder_if #(
  parameter int unsigned AW = 5
);
  logic          Start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [2:0]    in_a;
  logic [2:0]    in_b;
  logic [4:0]    in_imm;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic          Done;
  logic          err;
  logic [7:0]    err_count;
  logic [AW:0]   instr_count;

  modport master (
    output Start, in_valid, in_op, in_a, in_b, in_imm, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, Done, err, err_count, instr_count
  );

  modport slave (
    input  Start, in_valid, in_op, in_a, in_b, in_imm, in_last,
    output in_ready, wr_en, wr_addr, wr_data, Done, err, err_count, instr_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instruction fields into 9-bit words and writes them to
// instruction memory at sequential addresses, one load session per Start.
module instr_encoder #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 32
) (
  input logic            Clk,
  input logic            Reset,
  instr_encoder_if.slave bus
);

  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   acc_q, acc_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]    wr_data_q, wr_data_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [7:0]    errc_q, errc_d;
  logic          done_q, done_d;

  logic       in_ready;
  logic       accept;
  logic       legal;
  logic [8:0] enc;
  logic [2:0] a, b;
  logic [4:0] imm;

  assign a   = bus.in_a;
  assign b   = bus.in_b;
  assign imm = bus.in_imm;

  // Field packing; a 2-bit field with a[2] set or a 3-bit immediate above 7 is illegal.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    unique case (bus.in_op)
      4'd0:              enc = {4'b0000, a, b[1:0]};
      4'd1:              begin legal = !a[2]; enc = {4'b0001, a[1:0], b}; end
      4'd2, 4'd3, 4'd4:  begin
        legal = !a[2];
        enc   = {3'b010, bus.in_op[1:0] - 2'd2, a[1:0], b[1:0]};
      end
      4'd5, 4'd6, 4'd7:  enc = {5'b01011, bus.in_op[1:0] - 2'd1, b[1:0]};
      4'd8:              enc = {4'b1001, imm};
      4'd9:              begin legal = !a[2]; enc = {5'b10000, a[1:0], b[1:0]}; end
      4'd10:             enc = {3'b101, a, b};
      4'd11:             enc = {3'b110, a, b};
      4'd12:             enc = {3'b001, a, b};
      4'd13:             begin legal = (imm[4:3] == 2'b00); enc = {3'b011, a, imm[2:0]}; end
      4'd14:             begin
        legal = !a[2] && (imm[4:3] == 2'b00);
        enc   = {4'b1110, a[1:0], imm[2:0]};
      end
      4'd15:             begin
        legal = !a[2] && (imm[4:3] == 2'b00);
        enc   = {4'b1111, a[1:0], imm[2:0]};
      end
    endcase
  end

  assign in_ready = (state_q == StLoad) && (acc_q < DepthC);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    err_d     = err_q;
    errc_d    = errc_q;
    done_d    = done_q;
    // Address and count advance the cycle after each write is presented.
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + 1'b1;
      count_d   = count_q + 1'b1;
    end
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.Start) begin
          state_d   = StLoad;
          acc_d     = '0;
          wr_addr_d = '0;
          count_d   = '0;
          err_d     = 1'b0;
          errc_d    = '0;
          done_d    = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          if (legal) begin
            wr_en_d   = 1'b1;
            wr_data_d = enc;
            acc_d     = acc_q + 1'b1;
          end else begin
            err_d = 1'b1;
            if (errc_q != 8'hFF) errc_d = errc_q + 1'b1;
          end
          if (bus.in_last || (legal && (acc_q + 1'b1 == DepthC))) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      errc_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
      err_q     <= err_d;
      errc_q    <= errc_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.instr_count = count_q;
  assign bus.err         = err_q;
  assign bus.err_count   = errc_q;
  assign bus.Done        = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Drives two encoders (DEPTH 32 and DEPTH 4) with identical stimulus and
// compares every cycle against a session-level reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start, valid, last;
  logic [3:0] op;
  logic [2:0] a, b;
  logic [4:0] imm;

  instr_encoder_if #(.AW(5)) bus0 ();
  instr_encoder_if #(.AW(5)) bus1 ();

  assign bus0.Start = start;  assign bus1.Start = start;
  assign bus0.in_valid = valid;  assign bus1.in_valid = valid;
  assign bus0.in_op = op;  assign bus1.in_op = op;
  assign bus0.in_a = a;  assign bus1.in_a = a;
  assign bus0.in_b = b;  assign bus1.in_b = b;
  assign bus0.in_imm = imm;  assign bus1.in_imm = imm;
  assign bus0.in_last = last;  assign bus1.in_last = last;

  instr_encoder #(.AW(5), .DEPTH(32)) u_dut (.Clk(clk), .Reset(reset), .bus(bus0));
  instr_encoder #(.AW(5), .DEPTH(4))  u_dut4 (.Clk(clk), .Reset(reset), .bus(bus1));

  logic       o_wr_en [2], o_ready [2], o_done [2], o_err [2];
  logic [4:0] o_addr [2];
  logic [8:0] o_data [2];
  logic [7:0] o_errc [2];
  logic [5:0] o_cnt [2];
  assign o_wr_en[0] = bus0.wr_en;  assign o_wr_en[1] = bus1.wr_en;
  assign o_ready[0] = bus0.in_ready;  assign o_ready[1] = bus1.in_ready;
  assign o_done[0] = bus0.Done;  assign o_done[1] = bus1.Done;
  assign o_err[0] = bus0.err;  assign o_err[1] = bus1.err;
  assign o_addr[0] = bus0.wr_addr;  assign o_addr[1] = bus1.wr_addr;
  assign o_data[0] = bus0.wr_data;  assign o_data[1] = bus1.wr_data;
  assign o_errc[0] = bus0.err_count;  assign o_errc[1] = bus1.err_count;
  assign o_cnt[0] = bus0.instr_count;  assign o_cnt[1] = bus1.instr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per DUT
  int m_depth [2] = '{32, 4};
  bit m_load [2], m_err [2], m_done [2], m_wr [2];
  int m_acc [2], m_written [2], m_errc [2], m_data [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Machine word from the instruction table, computed as bit-weight sums.
  function automatic void encode(input int o, input int fa, input int fb, input int fi,
                                 output bit ok, output int w);
    ok = 1;
    w  = 0;
    case (o)
      0:       w = fa * 4 + fb % 4;
      1:       begin ok = fa < 4; w = 32 + (fa % 4) * 8 + fb; end
      2, 3, 4: begin ok = fa < 4; w = 128 + (o - 2) * 16 + (fa % 4) * 4 + fb % 4; end
      5, 6, 7: w = 176 + (o - 5) * 4 + fb % 4;
      8:       w = 288 + fi;
      9:       begin ok = fa < 4; w = 256 + (fa % 4) * 4 + fb % 4; end
      10:      w = 320 + fa * 8 + fb;
      11:      w = 384 + fa * 8 + fb;
      12:      w = 64 + fa * 8 + fb;
      13:      begin ok = fi < 8; w = 192 + fa * 8 + fi % 8; end
      14:      begin ok = fa < 4 && fi < 8; w = 448 + (fa % 4) * 8 + fi % 8; end
      default: begin ok = fa < 4 && fi < 8; w = 480 + (fa % 4) * 8 + fi % 8; end
    endcase
  endfunction

  // One clock: apply model at the edge, compare both DUTs on the falling edge.
  task automatic tick();
    bit ok;
    int w;
    encode(int'(op), int'(a), int'(b), int'(imm), ok, w);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_load[i] = 0; m_err[i] = 0; m_done[i] = 0; m_wr[i] = 0;
        m_acc[i] = 0; m_written[i] = 0; m_errc[i] = 0;
      end else begin
        bit accept;
        accept = m_load[i] && valid && (m_acc[i] < m_depth[i]);
        if (m_wr[i]) m_written[i]++;
        m_wr[i] = 0;
        if (start && !m_load[i]) begin
          m_load[i] = 1; m_err[i] = 0; m_done[i] = 0;
          m_acc[i] = 0; m_written[i] = 0; m_errc[i] = 0;
        end else if (accept) begin
          if (ok) begin
            m_wr[i] = 1; m_data[i] = w; m_acc[i]++;
          end else begin
            m_err[i] = 1;
            if (m_errc[i] < 255) m_errc[i]++;
          end
          if (last || m_acc[i] == m_depth[i]) begin
            m_load[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wr_en[%0d]", i), 32'(o_wr_en[i]), 32'(m_wr[i]));
      if (m_wr[i]) check($sformatf("wr_data[%0d]", i), 32'(o_data[i]), m_data[i]);
      check($sformatf("wr_addr[%0d]", i), 32'(o_addr[i]), m_written[i] % 32);
      check($sformatf("instr_count[%0d]", i), 32'(o_cnt[i]), m_written[i]);
      check($sformatf("in_ready[%0d]", i), 32'(o_ready[i]),
            32'(m_load[i] && m_acc[i] < m_depth[i]));
      check($sformatf("done[%0d]", i), 32'(o_done[i]), 32'(m_done[i]));
      check($sformatf("err[%0d]", i), 32'(o_err[i]), 32'(m_err[i]));
      check($sformatf("err_count[%0d]", i), 32'(o_errc[i]), m_errc[i]);
    end
  endtask

  task automatic idle(input int n);
    valid = 0; start = 0; last = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start();
    valid = 0; last = 0; start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input int o, input int fa, input int fb, input int fi, input bit l);
    op = 4'(o); a = 3'(fa); b = 3'(fb); imm = 5'(fi); last = l; valid = 1;
    tick();
    valid = 0; last = 0;
  endtask

  initial begin
    reset = 1; start = 0; valid = 0; last = 0; op = '0; a = '0; b = '0; imm = '0;
    tick(); tick();
    reset = 0;
    idle(2);

    // Directed program load
    pulse_start();
    send(0, 5, 2, 0, 0);
    check("tp_ld_data", 32'(bus0.wr_data), 32'h016);
    check("tp_ld_addr", 32'(bus0.wr_addr), 0);
    send(14, 2, 0, 7, 0);
    check("tp_addi", 32'(bus0.wr_data), 32'h1D7);
    send(8, 0, 0, 19, 0);
    check("tp_jmp", 32'(bus0.wr_data), 32'h133);
    send(3, 1, 3, 0, 0);
    check("tp_alu", 32'(bus0.wr_data), 32'h097);
    send(7, 0, 2, 0, 1);
    check("tp_flip", 32'(bus0.wr_data), 32'h0BA);
    check("tp_flip_addr", 32'(bus0.wr_addr), 4);
    check("tp_done", 32'(bus0.Done), 1);
    idle(1);
    check("tp_count", 32'(bus0.instr_count), 5);

    // Illegal fields
    pulse_start();
    send(1, 4, 0, 0, 0);
    check("tp_st_err", 32'(bus0.err_count), 1);
    send(14, 0, 0, 8, 0);
    check("tp_addi_err", 32'(bus0.err_count), 2);
    idle(2);

    // Depth limit: valid held for six legal bundles
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      op = 4'd12; a = 3'($urandom); b = 3'($urandom); valid = 1; last = 0;
      tick();
    end
    idle(2);
    check("tp_depth4_count", 32'(bus1.instr_count), 4);
    check("tp_depth4_done", 32'(bus1.Done), 1);

    // Reset together with an accepted bundle drops the write
    pulse_start();
    op = 4'd0; a = 3'd1; b = 3'd1; valid = 1; reset = 1;
    tick();
    reset = 0; valid = 0;
    check("tp_rst_wr_en", 32'(bus0.wr_en), 0);
    send(0, 1, 1, 0, 0);
    idle(1);
    pulse_start();
    send(0, 1, 1, 0, 0);

    // Error counter saturation
    pulse_start();
    for (int k = 0; k < 300; k++) begin
      op = 4'd1; a = 3'(4 + $urandom_range(0, 3)); b = 3'($urandom); valid = 1; last = 0;
      tick();
    end
    valid = 0;
    check("tp_err_sat", 32'(bus0.err_count), 255);
    idle(1);

    // Randomized sessions
    for (int k = 0; k < 800; k++) begin
      start = ($urandom_range(0, 19) == 0);
      valid = ($urandom_range(0, 9) < 7);
      last  = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 149) == 0);
      op = 4'($urandom); a = 3'($urandom); b = 3'($urandom); imm = 5'($urandom);
      tick();
    end
    reset = 0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
